// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator sequencer: FSM states, completion
// status codes, memory command codes and default burst/timeout limits.
package pci_pkg;

   localparam int unsigned MAX_BURST_DEF  = 16;
   localparam int unsigned DEVSEL_TMO_DEF = 5;

   localparam logic [3:0] MEM_RD = 4'h6;
   localparam logic [3:0] MEM_WR = 4'h7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_DATA,
      ST_ABORT,
      ST_TURN
   } state_e;

   typedef enum logic [1:0] {
      STS_OK     = 2'b00,
      STS_MABORT = 2'b01,
      STS_RETRY  = 2'b10,
      STS_DISC   = 2'b11
   } status_e;

endpackage

// File: rtl/pci_devsel_timer.sv
// Counts clocks after the address phase; expire holds while the count sits at TMO.
// Latency: count 1 in the first data clock. No backpressure; clear wins over start.
module pci_devsel_timer #(
   parameter int unsigned TMO = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic expire
);

   localparam int unsigned W = $clog2(TMO + 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         run_q, run_d;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (clear) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = W'(1);
      end else if (run_q && (cnt_q != W'(TMO))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign expire = run_q && (cnt_q == W'(TMO));

endmodule

// File: rtl/pci_master_seq.sv
// PCI initiator: arbitrates, drives address then data phases for one local command.
// Latency: ADDR two clocks after start when granted on an idle bus; target paces data via TRDY#/STOP#.
module pci_master_seq
   import pci_pkg::*;
#(
   parameter int unsigned MAX_BURST  = MAX_BURST_DEF,
   parameter int unsigned DEVSEL_TMO = DEVSEL_TMO_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        req_n,
   input  logic        gnt_n,
   input  logic        frame_in_n,
   input  logic        irdy_in_n,
   input  logic        trdy_n,
   input  logic        devsel_n,
   input  logic        stop_n,
   output logic        frame_n,
   output logic        frame_oe,
   output logic        irdy_n,
   output logic        irdy_oe,
   output logic [31:0] ad_out,
   output logic        ad_oe,
   input  logic [31:0] ad_in,
   output logic [3:0]  cbe_n,
   input  logic        start,
   input  logic [3:0]  cmd,
   input  logic [31:0] addr,
   input  logic [4:0]  len,
   input  logic [31:0] wdata,
   output logic        wdata_rd,
   output logic [31:0] rdata,
   output logic        rdata_vld,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status,
   output logic [4:0]  xfer_cnt
);

   state_e      state_q, state_d;
   status_e     status_q, status_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  rem_q, rem_d;
   logic [4:0]  xfer_q, xfer_d;
   logic        stop_q, stop_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_vld_q, rdata_vld_d;
   logic        final_ph;
   logic        tmr_start, tmr_clear, tmr_expire;

   // Runs from the address phase until the target claims the cycle.
   assign tmr_start = (state_q == ST_ADDR);
   assign tmr_clear = (state_q == ST_DATA) ? !devsel_n : (state_q != ST_ADDR);

   pci_devsel_timer #(.TMO(DEVSEL_TMO)) u_devsel_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (tmr_start),
      .clear  (tmr_clear),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d     = state_q;
      status_d    = status_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      xfer_d      = xfer_q;
      stop_d      = stop_q;
      rdata_d     = rdata_q;
      rdata_vld_d = 1'b0;
      final_ph    = 1'b0;
      req_n       = 1'b1;
      frame_n     = 1'b1;
      frame_oe    = 1'b0;
      irdy_n      = 1'b1;
      irdy_oe     = 1'b0;
      ad_out      = '0;
      ad_oe       = 1'b0;
      cbe_n       = 4'hF;
      wdata_rd    = 1'b0;
      done        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cmd_d    = cmd;
               addr_d   = addr;
               rem_d    = (len == 5'd0) ? 5'd1 :
                          ((len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : len);
               xfer_d   = '0;
               stop_d   = 1'b0;
               status_d = STS_OK;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            req_n = 1'b0;
            if (!gnt_n && frame_in_n && irdy_in_n) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            frame_n  = 1'b0;
            frame_oe = 1'b1;
            ad_out   = addr_q;
            ad_oe    = 1'b1;
            cbe_n    = cmd_q;
            state_d  = ST_DATA;
         end
         ST_DATA: begin
            // FRAME# drops on the last phase, or once the target has asked to stop.
            final_ph = (rem_q == 5'd1) || stop_q;
            frame_n  = final_ph;
            frame_oe = 1'b1;
            irdy_n   = 1'b0;
            irdy_oe  = 1'b1;
            cbe_n    = 4'h0;
            if (cmd_q[0]) begin
               ad_oe  = 1'b1;
               ad_out = wdata;
            end
            if (tmr_expire && devsel_n) begin
               status_d = STS_MABORT;
               state_d  = ST_ABORT;
            end else begin
               if (!trdy_n) begin
                  xfer_d = xfer_q + 5'd1;
                  rem_d  = rem_q - 5'd1;
                  if (cmd_q[0]) begin
                     wdata_rd = 1'b1;
                  end else begin
                     rdata_d     = ad_in;
                     rdata_vld_d = 1'b1;
                  end
               end
               if (!stop_n) stop_d = 1'b1;
               if (final_ph && (!trdy_n || !stop_n)) begin
                  state_d = ST_TURN;
                  if (stop_q || !stop_n)
                     status_d = (xfer_d == 5'd0) ? STS_RETRY : STS_DISC;
                  else
                     status_d = STS_OK;
               end
            end
         end
         ST_ABORT: begin
            frame_n  = 1'b1;
            frame_oe = 1'b1;
            irdy_n   = 1'b0;
            irdy_oe  = 1'b1;
            cbe_n    = 4'h0;
            state_d  = ST_TURN;
         end
         ST_TURN: begin
            frame_oe = 1'b1;
            irdy_oe  = 1'b1;
            done     = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         status_q    <= STS_OK;
         cmd_q       <= '0;
         addr_q      <= '0;
         rem_q       <= '0;
         xfer_q      <= '0;
         stop_q      <= 1'b0;
         rdata_q     <= '0;
         rdata_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         xfer_q      <= xfer_d;
         stop_q      <= stop_d;
         rdata_q     <= rdata_d;
         rdata_vld_q <= rdata_vld_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign status    = status_q;
   assign xfer_cnt  = xfer_q;
   assign rdata     = rdata_q;
   assign rdata_vld = rdata_vld_q;

endmodule

// File: tb/tb_pci_master_seq.sv
// Drives the sequencer with a reactive behavioural PCI target and arbiter and
// checks each transaction's outcome against rules-level expectations.
module tb_pci_master_seq;
   import pci_pkg::*;

   localparam int MAXB = int'(MAX_BURST_DEF);
   localparam int TMO  = int'(DEVSEL_TMO_DEF);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_n, frame_n, frame_oe, irdy_n, irdy_oe, ad_oe;
   logic        gnt_n = 1'b1, frame_in_n = 1'b1, irdy_in_n = 1'b1;
   logic        trdy_n = 1'b1, devsel_n = 1'b1, stop_n = 1'b1;
   logic [31:0] ad_out, rdata;
   logic [31:0] ad_in = '0, addr = '0, wdata = '0;
   logic [3:0]  cbe_n;
   logic [3:0]  cmd = '0;
   logic [4:0]  len = '0;
   logic        start = 1'b0;
   logic        wdata_rd, rdata_vld, busy, done;
   logic [1:0]  status;
   logic [4:0]  xfer_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pci_master_seq dut (
      .clk(clk), .rst_n(rst_n), .req_n(req_n), .gnt_n(gnt_n),
      .frame_in_n(frame_in_n), .irdy_in_n(irdy_in_n), .trdy_n(trdy_n),
      .devsel_n(devsel_n), .stop_n(stop_n), .frame_n(frame_n),
      .frame_oe(frame_oe), .irdy_n(irdy_n), .irdy_oe(irdy_oe),
      .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cbe_n(cbe_n),
      .start(start), .cmd(cmd), .addr(addr), .len(len), .wdata(wdata),
      .wdata_rd(wdata_rd), .rdata(rdata), .rdata_vld(rdata_vld),
      .busy(busy), .done(done), .status(status), .xfer_cnt(xfer_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One transaction: expected outcome from burst/stop/abort rules, target reacts per clock.
   task automatic run_txn(input bit wr, input logic [4:0] ln, input bit has_tgt,
                          input int dev_dly, input int stop_at, input bit stop_data,
                          input int waitp, input logic [31:0] a);
      int n, exp_x, acc, wr_cnt, rd_cnt, addr_cyc, k;
      bit done_seen, stopping, sdata, take;
      logic [1:0]  exp_st;
      logic [31:0] words [MAXB];

      n = (ln == 5'd0) ? 1 : ((int'(ln) > MAXB) ? MAXB : int'(ln));
      sdata = stop_data && (stop_at != n - 1);
      if (!has_tgt) begin
         exp_x = 0; exp_st = 2'b01;
      end else if (stop_at < 0 || stop_at >= n) begin
         exp_x = n; exp_st = 2'b00;
      end else begin
         exp_x = stop_at + (sdata ? 1 : 0);
         exp_st = (exp_x == 0) ? 2'b10 : 2'b11;
      end
      foreach (words[i]) words[i] = $urandom;
      acc = 0; wr_cnt = 0; rd_cnt = 0; addr_cyc = 0;
      done_seen = 1'b0; stopping = 1'b0;

      cmd = wr ? MEM_WR : MEM_RD; addr = a; len = ln; wdata = words[0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1; take = 1'b0;
         gnt_n = ($urandom_range(0, 2) == 0);
         if (rdata_vld) begin
            if (rd_cnt < MAXB) check_eq("rdata", rdata, words[rd_cnt]);
            rd_cnt++;
         end
         if (done) begin
            done_seen = 1'b1;
            check_eq("xfer_cnt", 32'(xfer_cnt), 32'(exp_x));
            check_eq("status", 32'(status), 32'(exp_st));
            check_eq("turn_oe", {29'd0, frame_oe, irdy_oe, ad_oe}, 32'h6);
            check_eq("turn_lines", {30'd0, frame_n, irdy_n}, 32'h3);
            if (!has_tgt) check_eq("abort_time", 32'(cyc - addr_cyc), 32'(TMO + 2));
         end else if (frame_oe && !frame_n && !irdy_oe) begin
            addr_cyc = cyc;
            check_eq("addr_ad", ad_out, a);
            check_eq("addr_cbe", 32'(cbe_n), 32'(cmd));
         end else if (irdy_oe && !irdy_n && has_tgt) begin
            k = cyc - addr_cyc;
            if (k >= dev_dly) devsel_n = 1'b0;
            if (stopping) begin
               stop_n = 1'b0;
               check_eq("frame_after_stop", 32'(frame_n), 32'd1);
            end else if (k > dev_dly) begin
               check_eq("frame_last", 32'(frame_n), 32'(acc == n - 1));
               if (acc == stop_at) begin
                  stop_n = 1'b0; stopping = 1'b1; take = sdata;
               end else if ($urandom_range(0, 99) >= waitp) begin
                  take = 1'b1;
               end
            end
            if (take) begin
               trdy_n = 1'b0;
               if (wr) check_eq("wr_ad", ad_out, words[acc]);
               else    ad_in = words[acc];
               acc++;
            end
         end
         #1;
         if (wdata_rd) begin
            wr_cnt++;
            if (wr_cnt < MAXB) wdata = words[wr_cnt];
         end
         @(negedge clk);
      end
      devsel_n = 1'b1; trdy_n = 1'b1; stop_n = 1'b1;
      if (!done_seen) check_eq("done_timeout", 32'd0, 32'd1);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("oe_after", {29'd0, frame_oe, irdy_oe, ad_oe}, 32'd0);
      check_eq("wr_pulses", 32'(wr_cnt), wr ? 32'(exp_x) : 32'd0);
      check_eq("rd_pulses", 32'(rd_cnt), wr ? 32'd0 : 32'(exp_x));
   endtask

   initial begin
      #1;
      check_eq("rst_req", 32'(req_n), 32'd1);
      check_eq("rst_lines", {30'd0, frame_n, irdy_n}, 32'h3);
      check_eq("rst_oe", {29'd0, frame_oe, irdy_oe, ad_oe}, 32'd0);
      check_eq("rst_pulses", {29'd0, done, wdata_rd, rdata_vld}, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_status", {25'd0, status, xfer_cnt}, 32'd0);
      check_eq("rst_data", ad_out | rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(1'b1, 5'd1,  1'b1, 1, -1, 1'b0, 0,  32'h0000_1000); // single write
      run_txn(1'b0, 5'd4,  1'b1, 1, -1, 1'b0, 0,  $urandom);      // read burst
      run_txn(1'b1, 5'd3,  1'b0, 1, -1, 1'b0, 0,  $urandom);      // master abort
      run_txn(1'b0, 5'd4,  1'b1, 0, 0,  1'b0, 0,  $urandom);      // retry
      run_txn(1'b1, 5'd4,  1'b1, 1, 2,  1'b0, 0,  $urandom);      // disconnect after 2
      run_txn(1'b0, 5'd4,  1'b1, 1, 1,  1'b1, 0,  $urandom);      // stop with data
      run_txn(1'b0, 5'd0,  1'b1, 2, -1, 1'b0, 20, $urandom);      // len 0 -> 1
      run_txn(1'b1, 5'd20, 1'b1, 1, -1, 1'b0, 20, $urandom);      // clamp to max

      for (int t = 0; t < 40; t++) begin
         run_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1,
                 1'($urandom_range(0, 1)), 30, $urandom);
      end

      // Arbitration hold-off, bus-busy hold-off, then reset in the data phase.
      gnt_n = 1'b1; cmd = MEM_RD; addr = 32'h0000_2000; len = 5'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq("nognt_req", 32'(req_n), 32'd0);
         check_eq("nognt_frame", 32'(frame_oe), 32'd0);
         @(negedge clk);
      end
      gnt_n = 1'b0; frame_in_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("busbusy_req", 32'(req_n), 32'd0);
         check_eq("busbusy_frame", 32'(frame_oe), 32'd0);
      end
      frame_in_n = 1'b1;
      @(negedge clk);
      check_eq("idle_addr", {30'd0, frame_oe, frame_n}, 32'h2);
      check_eq("idle_addr_ad", ad_out, 32'h0000_2000);
      devsel_n = 1'b0;
      @(negedge clk);
      check_eq("data_irdy", {30'd0, irdy_oe, irdy_n}, 32'h2);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_oe", {29'd0, frame_oe, irdy_oe, ad_oe}, 32'd0);
      check_eq("rst_mid_done", 32'(done), 32'd0);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("rst_hold_done", 32'(done), 32'd0);
      devsel_n = 1'b1; gnt_n = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_req", 32'(req_n), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
